// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcode/funct
// values, instruction classes and datapath select codes.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    C_NONE, C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW,
    C_BEQ, C_J, C_JAL, C_JR
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] PC_RS  = 2'b11;

  localparam logic [1:0] REG_RT = 2'b00;
  localparam logic [1:0] REG_RD = 2'b01;
  localparam logic [1:0] REG_RA = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_OR    = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  // Register-register ALU ops write rd; everything else writes rt or $31.
  function automatic logic is_rtype_alu(input iclass_e c);
    return (c == C_ADDU) || (c == C_SUBU);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction-to-class decoder; anything not recognised
// (including the all-zero nop) maps to C_NONE.
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0] instr_i,
  output iclass_e     iclass_o
);

  logic unused_fields;
  assign unused_fields = ^instr_i[25:6];

  always_comb begin
    iclass_o = C_NONE;
    case (instr_i[31:26])
      OP_RTYPE: begin
        case (instr_i[5:0])
          FN_ADDU: iclass_o = C_ADDU;
          FN_SUBU: iclass_o = C_SUBU;
          FN_JR:   iclass_o = C_JR;
          default: iclass_o = C_NONE;
        endcase
      end
      OP_ORI:  iclass_o = C_ORI;
      OP_LUI:  iclass_o = C_LUI;
      OP_LW:   iclass_o = C_LW;
      OP_SW:   iclass_o = C_SW;
      OP_BEQ:  iclass_o = C_BEQ;
      OP_J:    iclass_o = C_J;
      OP_JAL:  iclass_o = C_JAL;
      default: iclass_o = C_NONE;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM. Define MC_CTRL_PERF_EN to add the
// PERF_W-bit retired-instruction counter and its retired output port.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              zero,
  input  logic              mem_rdy,
  output logic              mem_req,
  output logic              memwrite,
  output logic              irwrite,
  output logic              pcwrite,
  output logic [1:0]        pcsrc,
  output logic              regwrite,
  output logic [1:0]        regdst,
  output logic [1:0]        memtoreg,
  output logic              alusrc,
  output logic [1:0]        aluctrl,
  output logic [1:0]        extop,
  output logic [2:0]        state_o
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] retired
`endif
);

  state_e  state_q, state_d;
  iclass_e iclass;
  logic    retire;

  mc_decode u_decode (
    .instr_i  (instr),
    .iclass_o (iclass)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign state_o = state_q;

  always_comb begin
    state_d  = S_FETCH;
    retire   = 1'b0;
    mem_req  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    pcsrc    = PC_SEQ;
    regwrite = 1'b0;
    regdst   = REG_RT;
    memtoreg = WB_ALU;
    alusrc   = 1'b0;
    aluctrl  = ALU_ADD;
    extop    = EXT_ZERO;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (iclass == C_NONE) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (iclass)
          C_ADDU: state_d = S_WB;
          C_SUBU: begin aluctrl = ALU_SUB; state_d = S_WB; end
          C_ORI: begin
            aluctrl = ALU_OR; alusrc = 1'b1; extop = EXT_ZERO; state_d = S_WB;
          end
          C_LUI: begin
            aluctrl = ALU_PASSB; alusrc = 1'b1; extop = EXT_UPPER; state_d = S_WB;
          end
          C_LW, C_SW: begin
            aluctrl = ALU_ADD; alusrc = 1'b1; extop = EXT_SIGN; state_d = S_MEM;
          end
          C_BEQ: begin
            aluctrl = ALU_SUB; pcsrc = PC_BR; pcwrite = zero; retire = 1'b1;
          end
          C_J:   begin pcwrite = 1'b1; pcsrc = PC_JMP; retire = 1'b1; end
          C_JAL: begin
            pcwrite  = 1'b1; pcsrc  = PC_JMP; regwrite = 1'b1;
            regdst   = REG_RA; memtoreg = WB_PC4; retire = 1'b1;
          end
          C_JR:  begin pcwrite = 1'b1; pcsrc = PC_RS; retire = 1'b1; end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        memwrite = (iclass == C_SW);
        if (!mem_rdy)              state_d = S_MEM;
        else if (iclass == C_LW)   state_d = S_WB;
        else begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        regwrite = 1'b1;
        regdst   = is_rtype_alu(iclass) ? REG_RD : REG_RT;
        memtoreg = (iclass == C_LW) ? WB_MEM : WB_ALU;
        retire   = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset kills every output combinationally so an in-flight access drops at once.
    if (!reset) begin
      retire   = 1'b0;
      mem_req  = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      pcsrc    = PC_SEQ;
      regwrite = 1'b0;
      regdst   = REG_RT;
      memtoreg = WB_ALU;
      alusrc   = 1'b0;
      aluctrl  = ALU_ADD;
      extop    = EXT_ZERO;
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [PERF_W-1:0] retired_q, retired_d;

  assign retired_d = retire ? retired_q + 1'b1 : retired_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) retired_q <= '0;
    else        retired_q <= retired_d;
  end

  assign retired = retired_q;
`else
  logic [PERF_W:0] unused_perf;
  assign unused_perf = {{PERF_W{1'b0}}, retire};
`endif

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter PERF_W, default 32: width of the retired-instruction counter; used only when MC_CTRL_PERF_EN is defined.
REQ-002 clk  input  1: single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1: asynchronous, active-low reset.
REQ-004 instr  input  32: current instruction register contents.
REQ-005 zero  input  1: ALU equality flag, valid in EXEC.
REQ-006 mem_rdy  input  1: memory completion strobe, shared by instruction and data accesses.
REQ-007 mem_req  output  1: memory access request, held until mem_rdy.
REQ-008 memwrite  output  1: data store strobe.
REQ-009 irwrite  output  1: IR load strobe.
REQ-010 pcwrite  output  1: PC update strobe.
REQ-011 pcsrc  output  2: PC source: 00 = pc+4, 01 = branch target, 10 = jump target, 11 = rs.
REQ-012 regwrite  output  1: register file write strobe.
REQ-013 regdst  output  2: destination register: 00 = rt, 01 = rd, 10 = $31.
REQ-014 memtoreg  output  2: write-back source: 00 = ALU, 01 = memory, 10 = pc+4.
REQ-015 alusrc  output  1: ALU B operand: 0 = rt, 1 = immediate.
REQ-016 aluctrl  output  2: ALU operation: 00 = add, 01 = sub, 10 = or, 11 = pass-B.
REQ-017 extop  output  2: immediate extension: 00 = zero, 01 = sign, 10 = upper-16.
REQ-018 state_o  output  3: current state code, for debug.
REQ-019 retired  output  PERF_W: count of retired instructions; present only with the macro defined.

Function
REQ-020 States and encodings SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; all other codes SHALL return to FETCH on the next edge.
REQ-021 FETCH: assert mem_req; on mem_rdy, pulse irwrite and pcwrite (pcsrc=00) in the same cycle and go to DECODE; otherwise hold FETCH.
REQ-022 DECODE: one cycle, no strobes asserted; supported opcodes go to EXEC; unsupported opcodes and all-zero instructions (nop) go to FETCH and count as retired.
REQ-023 EXEC, addu/subu/ori/lui: drive the ALU controls, then go to WB.
REQ-024 EXEC, lw/sw: aluctrl=00, alusrc=1, extop=01, then go to MEM.
REQ-025 EXEC, beq: aluctrl=01; pcwrite = zero with pcsrc=01; then go to FETCH.
REQ-026 EXEC, j: pcwrite with pcsrc=10, then go to FETCH.
REQ-027 EXEC, jal: pcwrite with pcsrc=10, plus regwrite with regdst=10 and memtoreg=10, then go to FETCH.
REQ-028 EXEC, jr: pcwrite with pcsrc=11, then go to FETCH.
REQ-029 MEM: assert mem_req, with memwrite=1 for sw; on mem_rdy, sw goes to FETCH and lw goes to WB; without mem_rdy, hold MEM with all controls stable.
REQ-030 WB: pulse regwrite for one cycle (regdst=01 for R-type, 00 otherwise; memtoreg=01 for lw, 00 otherwise), then go to FETCH.
REQ-031 Latency in cycles with zero wait states: R/I-type 4, lw 5, sw 4, beq/j/jal/jr 3.
REQ-032 Strobes (irwrite, pcwrite, regwrite, memwrite) SHALL be asserted for at most one cycle per instruction.
REQ-033 Data-path select outputs SHALL be a combinational function of state and instr; strobes SHALL never be asserted in DECODE.
REQ-034 mem_rdy outside FETCH and MEM SHALL be ignored.

Reset
REQ-035 While reset is low: state=FETCH, all outputs 0, retired=0.
REQ-036 Reset asserted mid-instruction aborts it: no partial write, and mem_req drops asynchronously.
REQ-037 The first FETCH request SHALL begin in the first cycle after reset deasserts.

Configuration
REQ-038 Macro MC_CTRL_PERF_EN defined: retired port present; it increments by 1 at each instruction's final state and wraps modulo 2^PERF_W.
REQ-039 Macro MC_CTRL_PERF_EN undefined: no retired port and no counter logic.

Structure
REQ-040 Shared package mc_pkg SHALL hold the state encodings, opcode/funct constants, and pcsrc/regdst/memtoreg/aluctrl/extop codes.
REQ-041 One sub-module, mc_decode, SHALL be a combinational instr-to-class decoder; the state machine stays in mc_ctrl.

Verification
REQ-042 addu $3,$1,$2 (0x00221821) with mem_rdy always 1 -> states 0,1,2,4,0; one regwrite pulse in WB with regdst=01, memtoreg=00.
REQ-043 lw with mem_rdy held low 3 cycles in MEM -> MEM held 3 extra cycles, mem_req stable, regwrite in WB with memtoreg=01; total 8 cycles.
REQ-044 beq with zero=1, then zero=0 -> pcwrite with pcsrc=01 in EXEC only for the first; 3 cycles each.
REQ-045 jal 0x0C000010 -> EXEC pulses pcwrite (pcsrc=10) and regwrite (regdst=10, memtoreg=10) together.
REQ-046 reset pulled low during MEM of sw -> memwrite and mem_req go to 0 immediately; FETCH resumes after release; retired unchanged.
REQ-047 With MC_CTRL_PERF_EN, PERF_W=4, run 17 nops -> retired=1.
